// File: rtl/vz_load_commit.sv
// vz_load_commit: turns the VZ loader's level-style write stream into single-cycle
// RAM writes, buffers them in a small FIFO that drains only when the CPU leaves the
// RAM port idle, and after an execute request injects "JP nn" at the next opcode fetch.
module vz_load_commit #(
    parameter int unsigned FIFO_AW   = 2,
    parameter logic [7:0]  JP_OPCODE = 8'hC3
) (
    input  logic        I_CLK,
    input  logic        I_RST_N,
    input  logic [15:0] I_VZ_ADDR,
    input  logic [7:0]  I_VZ_DATA,
    input  logic        I_VZ_WR,
    input  logic [15:0] I_EXEC_ADDR,
    input  logic        I_EXEC_EN,
    input  logic        I_RAM_BUSY,
    output logic [15:0] O_RAM_ADDR,
    output logic [7:0]  O_RAM_DATA,
    output logic        O_RAM_WE,
    input  logic        I_CPU_M1_N,
    input  logic        I_CPU_RD_N,
    output logic        O_OVR_EN,
    output logic [7:0]  O_OVR_DATA,
    output logic        O_BUSY,
    output logic        O_OVF
);

    localparam int unsigned Depth = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StOp,
        StLo,
        StHi
    } jp_state_e;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [23:0]      fifo_mem [Depth];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic             fifo_empty;
    logic             fifo_full;

    // Last-write register used to collapse a held write into one entry
    logic [23:0]      last_wr_q;
    logic             last_wr_valid_q;

    // Registered RAM write port
    logic [15:0]      ram_addr_q;
    logic [7:0]       ram_data_q;
    logic             ram_we_q;
    logic             ovf_q;
    logic             busy_q;

    // Jump sequencer
    jp_state_e        state_q;
    logic [15:0]      jp_addr_q;
    logic             ovr_en_q;
    logic [7:0]       ovr_data_q;
    logic             rd_n_q;
    logic             exec_en_q;

    logic [23:0]      wr_word;
    logic             enq_req;
    logic             enq;
    logic             deq;
    logic             drop;
    logic             drained;
    logic             rd_fall;
    logic             rd_rise;
    logic             exec_rise;

    // FIFO status and handshake decode
    always_comb begin
        wr_word    = {I_VZ_ADDR, I_VZ_DATA};
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        enq_req    = I_VZ_WR && (!last_wr_valid_q || (wr_word != last_wr_q));
        deq        = !fifo_empty && !I_RAM_BUSY;
        // A full FIFO still accepts a write when it is popping in the same cycle
        enq        = enq_req && (!fifo_full || deq);
        drop       = enq_req && fifo_full && !deq;
        // Nothing left to commit: no stored entry, no strobe on the port, no new entry
        drained    = fifo_empty && !ram_we_q && !enq;
        rd_fall    = rd_n_q && !I_CPU_RD_N;
        rd_rise    = !rd_n_q && I_CPU_RD_N;
        exec_rise  = I_EXEC_EN && !exec_en_q;
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge I_CLK) begin
        if (enq) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
        end
    end

    // FIFO pointers
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Last-write tracking; a dropped write is also remembered so a held write
    // against a full FIFO is not retried every cycle
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            last_wr_q       <= '0;
            last_wr_valid_q <= 1'b0;
        end else if (!I_VZ_WR) begin
            last_wr_valid_q <= 1'b0;
        end else if (enq_req) begin
            last_wr_q       <= wr_word;
            last_wr_valid_q <= 1'b1;
        end
    end

    // RAM write port: one strobe per dequeued entry, address/data hold otherwise
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            ram_we_q <= deq;
            if (deq) begin
                {ram_addr_q, ram_data_q} <= fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
            end
        end
    end

    // Sticky overflow flag and busy status
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_q | drop;
            busy_q <= !fifo_empty || ram_we_q || (state_q != StIdle);
        end
    end

    // Jump injection sequencer: JP opcode, then low and high address bytes
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q    <= StIdle;
            jp_addr_q  <= '0;
            ovr_en_q   <= 1'b0;
            ovr_data_q <= '0;
            rd_n_q     <= 1'b1;
            exec_en_q  <= 1'b0;
        end else begin
            rd_n_q    <= I_CPU_RD_N;
            exec_en_q <= I_EXEC_EN;
            unique case (state_q)
                StIdle: begin
                    if (exec_rise) begin
                        jp_addr_q <= I_EXEC_ADDR;
                        state_q   <= StArmed;
                    end
                end
                StArmed: begin
                    // Fetches seen before the FIFO drains pass through untouched
                    if (drained && !I_CPU_M1_N && rd_fall) begin
                        ovr_en_q   <= 1'b1;
                        ovr_data_q <= JP_OPCODE;
                        state_q    <= StOp;
                    end
                end
                StOp: begin
                    if (rd_rise) begin
                        ovr_en_q <= 1'b0;
                        state_q  <= StLo;
                    end
                end
                StLo: begin
                    if (rd_fall) begin
                        ovr_en_q   <= 1'b1;
                        ovr_data_q <= jp_addr_q[7:0];
                    end else if (rd_rise && ovr_en_q) begin
                        ovr_en_q <= 1'b0;
                        state_q  <= StHi;
                    end
                end
                StHi: begin
                    if (rd_fall) begin
                        ovr_en_q   <= 1'b1;
                        ovr_data_q <= jp_addr_q[15:8];
                    end else if (rd_rise && ovr_en_q) begin
                        ovr_en_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    ovr_en_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    // Override is gated by RD so it never outlives the read strobe
    assign O_OVR_EN   = ovr_en_q && !I_CPU_RD_N;
    assign O_OVR_DATA = ovr_data_q;
    assign O_RAM_ADDR = ram_addr_q;
    assign O_RAM_DATA = ram_data_q;
    assign O_RAM_WE   = ram_we_q;
    assign O_BUSY     = busy_q;
    assign O_OVF      = ovf_q;

endmodule

// File: tb/tb_vz_load_commit.sv
// Self-checking bench for vz_load_commit: table-driven vectors, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_vz_load_commit;

    logic        clk;
    logic        rst_n;
    logic [15:0] vz_addr;
    logic [7:0]  vz_data;
    logic        vz_wr;
    logic [15:0] exec_addr;
    logic        exec_en;
    logic        ram_busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic        m1_n;
    logic        rd_n;
    logic        ovr_en;
    logic [7:0]  ovr_data;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    vz_load_commit #(
        .FIFO_AW   (2),
        .JP_OPCODE (8'hC3)
    ) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
        .I_VZ_ADDR   (vz_addr),
        .I_VZ_DATA   (vz_data),
        .I_VZ_WR     (vz_wr),
        .I_EXEC_ADDR (exec_addr),
        .I_EXEC_EN   (exec_en),
        .I_RAM_BUSY  (ram_busy),
        .O_RAM_ADDR  (ram_addr),
        .O_RAM_DATA  (ram_data),
        .O_RAM_WE    (ram_we),
        .I_CPU_M1_N  (m1_n),
        .I_CPU_RD_N  (rd_n),
        .O_OVR_EN    (ovr_en),
        .O_OVR_DATA  (ovr_data),
        .O_BUSY      (busy),
        .O_OVF       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rbusy;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One CPU read cycle; reports override state mid-read and after RD rises
    task automatic fetch(input logic with_m1, output logic en_low, output logic [7:0] dat,
                         output logic en_after);
        m1_n = !with_m1;
        rd_n = 1'b0;
        tick();
        tick();
        tick();
        en_low = ovr_en;
        dat    = ovr_data;
        rd_n   = 1'b1;
        m1_n   = 1'b1;
        tick();
        en_after = ovr_en;
        tick();
    endtask

    task automatic write_one(input logic [15:0] a, input logic [7:0] d);
        vz_wr   = 1'b1;
        vz_addr = a;
        vz_data = d;
        tick();
    endtask

    initial begin : main
        logic        e_lo;
        logic        e_af;
        logic [7:0]  d;
        int          pulses;
        int          first_pulse;
        logic [23:0] got[$];
        logic [23:0] mq[$];
        logic [23:0] m_out;
        logic [23:0] m_lw;
        logic        m_lw_v;
        logic        m_we;
        logic        m_ovf;
        logic [23:0] w;
        logic        r_wr;
        logic        r_busy;
        logic        attempt;

        rst_n     = 1'b0;
        vz_addr   = '0;
        vz_data   = '0;
        vz_wr     = 1'b0;
        exec_addr = '0;
        exec_en   = 1'b0;
        ram_busy  = 1'b0;
        m1_n      = 1'b1;
        rd_n      = 1'b1;

        // Held write at 7AE9/55 for 10 cycles: one strobe, two cycles after first WR
        for (int i = 0; i < 11; i++) begin
            tbl[i].wr       = (i < 10);
            tbl[i].addr     = 16'h7AE9;
            tbl[i].data     = 8'h55;
            tbl[i].rbusy    = 1'b0;
            tbl[i].exp_we   = (i == 1);
            tbl[i].exp_addr = (i >= 1) ? 16'h7AE9 : 16'h0000;
            tbl[i].exp_data = (i >= 1) ? 8'h55 : 8'h00;
            tbl[i].exp_ovf  = 1'b0;
        end

        tick();
        chk("reset_we", ram_we, 0);
        chk("reset_ovr_en", ovr_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_ram_addr", ram_addr, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            vz_wr    = tbl[i].wr;
            vz_addr  = tbl[i].addr;
            vz_data  = tbl[i].data;
            ram_busy = tbl[i].rbusy;
            tick();
            chk($sformatf("tbl%0d_we", i), ram_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_data", i), ram_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].exp_ovf);
        end

        // Three writes held off by a busy RAM port, then drained back to back
        ram_busy = 1'b1;
        write_one(16'h8000, 8'h01);
        write_one(16'h8001, 8'h02);
        write_one(16'h8002, 8'h03);
        vz_wr  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_we) pulses++;
        end
        chk("busy_hold_no_we", pulses, 0);
        ram_busy    = 1'b0;
        got.delete();
        first_pulse = -1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ram_we) begin
                if (first_pulse < 0) first_pulse = i;
                got.push_back({ram_addr, ram_data});
            end
        end
        chk("three_count", got.size(), 3);
        chk("three_first_cycle", first_pulse, 0);
        if (got.size() == 3) begin
            chk("three_e0", got[0], 24'h8000_01);
            chk("three_e1", got[1], 24'h8001_02);
            chk("three_e2", got[2], 24'h8002_03);
        end
        chk("three_ovf", ovf, 0);

        // Six writes into a 4-deep FIFO: last two dropped, overflow sticky
        ram_busy = 1'b1;
        for (int i = 0; i < 6; i++) write_one(16'h9000 + 16'(i), 8'h10 + 8'(i));
        vz_wr    = 1'b0;
        ram_busy = 1'b0;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_we) got.push_back({ram_addr, ram_data});
        end
        chk("ovf_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk($sformatf("ovf_e%0d", i), got[i], {16'h9000 + 16'(i), 8'h10 + 8'(i)});
        end
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // Execute request with empty FIFO: C3, 00, 80 then idle
        exec_addr = 16'h8000;
        exec_en   = 1'b1;
        tick();
        fetch(1'b1, e_lo, d, e_af);
        chk("jp_op_en", e_lo, 1);
        chk("jp_op_data", d, 8'hC3);
        chk("jp_op_release", e_af, 0);
        fetch(1'b0, e_lo, d, e_af);
        chk("jp_lo_en", e_lo, 1);
        chk("jp_lo_data", d, 8'h00);
        fetch(1'b0, e_lo, d, e_af);
        chk("jp_hi_en", e_lo, 1);
        chk("jp_hi_data", d, 8'h80);
        chk("jp_hi_release", e_af, 0);
        tick();
        tick();
        chk("jp_done_busy", busy, 0);
        // EXEC_EN still high: no re-arm
        fetch(1'b1, e_lo, d, e_af);
        chk("jp_no_rearm", e_lo, 0);
        exec_en = 1'b0;
        tick();

        // Execute request with two entries pending: first fetch passes through
        ram_busy = 1'b1;
        write_one(16'hA000, 8'hAA);
        write_one(16'hA001, 8'hBB);
        vz_wr     = 1'b0;
        exec_addr = 16'h1234;
        exec_en   = 1'b1;
        tick();
        exec_en = 1'b0;
        fetch(1'b1, e_lo, d, e_af);
        chk("pend_passthru", e_lo, 0);
        chk("pend_busy", busy, 1);
        ram_busy = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ram_we) pulses++;
        end
        chk("pend_drain", pulses, 2);
        fetch(1'b1, e_lo, d, e_af);
        chk("pend_op_en", e_lo, 1);
        chk("pend_op_data", d, 8'hC3);
        fetch(1'b0, e_lo, d, e_af);
        chk("pend_lo_data", d, 8'h34);
        fetch(1'b0, e_lo, d, e_af);
        chk("pend_hi_data", d, 8'h12);

        // Reset while in LO with override active and the FIFO loaded
        exec_addr = 16'h5678;
        exec_en   = 1'b1;
        tick();
        exec_en = 1'b0;
        fetch(1'b1, e_lo, d, e_af);
        chk("rst_op_data", d, 8'hC3);
        ram_busy = 1'b1;
        write_one(16'hB000, 8'h01);
        write_one(16'hB001, 8'h02);
        write_one(16'hB002, 8'h03);
        vz_wr = 1'b0;
        rd_n  = 1'b0;
        tick();
        tick();
        chk("rst_pre_ovr_en", ovr_en, 1);
        chk("rst_pre_ovr_data", ovr_data, 8'h78);
        ram_busy = 1'b0;
        tick();
        chk("rst_pre_we", ram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ovr_en", ovr_en, 0);
        chk("rst_async_we", ram_we, 0);
        chk("rst_async_busy", busy, 0);
        rd_n = 1'b1;
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_we) pulses++;
        end
        chk("rst_post_no_we", pulses, 0);
        chk("rst_post_busy", busy, 0);
        fetch(1'b1, e_lo, d, e_af);
        chk("rst_post_idle", e_lo, 0);

        // Randomized write stream against a queue model
        do_reset();
        mq.delete();
        m_out  = '0;
        m_lw   = '0;
        m_lw_v = 1'b0;
        m_we   = 1'b0;
        m_ovf  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_wr   = ($urandom_range(0, 3) != 0);
            r_busy = ($urandom_range(0, 1) != 0);
            w      = {14'h3000, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 2))};
            vz_wr    = r_wr;
            vz_addr  = w[23:8];
            vz_data  = w[7:0];
            ram_busy = r_busy;
            // Model: pop if anything stored and port free; push new distinct write
            attempt = r_wr && (!m_lw_v || (w != m_lw));
            if (mq.size() > 0 && !r_busy) begin
                m_out = mq.pop_front();
                m_we  = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (attempt) begin
                if (mq.size() < 4) mq.push_back(w);
                else m_ovf = 1'b1;
                m_lw   = w;
                m_lw_v = 1'b1;
            end
            if (!r_wr) m_lw_v = 1'b0;
            tick();
            chk($sformatf("rnd%0d_we", n), ram_we, m_we);
            chk($sformatf("rnd%0d_word", n), {ram_addr, ram_data}, m_out);
            chk($sformatf("rnd%0d_ovf", n), ovf, m_ovf);
            chk($sformatf("rnd%0d_ovr", n), ovr_en, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vz_load_commit.md
Name: vz_load_commit

Overview:
- Sits directly downstream of the VZ loader.
- Turns its level-style write stream (address, data, write-enable held high) into discrete single-cycle RAM writes.
- Buffers those writes in a small FIFO and commits them to the shared system RAM port only in cycles the CPU does not own it.
- After the loader raises its execute request and the FIFO has drained, injects a 3-byte `JP nn` onto the Z80 data bus at the next opcode fetch, so machine-code programs auto-start.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth = 2**FIFO_AW = 4 entries of 24 bits {addr,data}).
- JP_OPCODE, 8'hC3, opcode byte injected on the first override fetch.

Ports:
- I_CLK  in  1  system clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_VZ_ADDR  in  16  loader write address.
- I_VZ_DATA  in  8  loader write data.
- I_VZ_WR  in  1  loader write-enable, level; may stay high for many cycles.
- I_EXEC_ADDR  in  16  program start address.
- I_EXEC_EN  in  1  loader execute request, level.
- I_RAM_BUSY  in  1  1 = CPU owns the RAM port this cycle.
- O_RAM_ADDR  out  16  RAM write address.
- O_RAM_DATA  out  8  RAM write data.
- O_RAM_WE  out  1  one-cycle RAM write strobe.
- I_CPU_M1_N  in  1  Z80 M1, active low.
- I_CPU_RD_N  in  1  Z80 RD, active low (memory reads only).
- O_OVR_EN  out  1  1 = override CPU data-in with O_OVR_DATA.
- O_OVR_DATA  out  8  injected byte.
- O_BUSY  out  1  FIFO non-empty or jump sequence not in IDLE.
- O_OVF  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, I_RST_N=0): FIFO empty, pointers 0, all outputs 0, FSM IDLE, last-write register invalid. Applies immediately, including mid-sequence.
- Enqueue condition: I_VZ_WR=1 and (last-write register invalid, or {I_VZ_ADDR,I_VZ_DATA} differs from it).
  - On enqueue, store {addr,data} in the FIFO and the last-write register; mark it valid.
  - I_VZ_WR=0 for a cycle invalidates the last-write register, so a repeated identical write after a gap is enqueued again.
- Full: enqueue attempted while full and no dequeue this cycle -> entry dropped, O_OVF set until reset. Enqueue and dequeue in the same cycle while full is legal; nothing is dropped.
- Dequeue: FIFO non-empty and I_RAM_BUSY=0 -> registered output.
  - Next cycle: O_RAM_WE=1 with the head entry on O_RAM_ADDR/O_RAM_DATA.
  - Latency from enqueue to O_RAM_WE is 2 cycles minimum.
  - O_RAM_WE is high at most 1 cycle per entry; O_RAM_ADDR/DATA hold their last value when WE=0.
- FIFO ordering is strict; pointers wrap modulo depth, with an extra MSB for full/empty.
- Jump FSM (RD falling/rising detected from a registered copy of I_CPU_RD_N):
  - IDLE: I_EXEC_EN rising edge latches I_EXEC_ADDR -> ARMED.
  - ARMED: waits until the FIFO is empty and no write is pending. On a cycle with I_CPU_M1_N=0 and RD_N falling -> OP.
  - OP: O_OVR_EN=1, O_OVR_DATA=JP_OPCODE while RD_N=0. RD_N rising -> LO.
  - LO: on next RD_N low, drive the low address byte. RD_N rising -> HI.
  - HI: on next RD_N low, drive the high address byte. RD_N rising -> IDLE.
  - Outside those RD_N-low windows O_OVR_EN=0. M1 is not required in LO/HI.
- I_EXEC_EN held high does not re-arm; only a new rising edge in IDLE arms. A rising edge outside IDLE is ignored.
- An M1 fetch in ARMED while the FIFO is non-empty is passed through untouched; the FSM stays ARMED.
- O_BUSY = (FIFO not empty) | WE pending | (FSM != IDLE), registered.

Test Plan:
- Hold I_VZ_WR=1 for 10 cycles at addr 7AE9/data 55 -> exactly one O_RAM_WE pulse, addr 7AE9, data 55, 2 cycles after first WR.
- Stream 3 distinct writes (8000/01, 8001/02, 8002/03) with I_RAM_BUSY=1 for 20 cycles, then 0 -> three consecutive WE pulses in order, O_OVF=0.
- 6 distinct writes in consecutive cycles with I_RAM_BUSY=1 -> first 4 committed after release, writes 5 and 6 dropped, O_OVF=1 until reset.
- I_EXEC_EN rising with exec addr 8000, FIFO empty, then three RD cycles (first with M1=0) -> override bytes C3, 00, 80, then O_OVR_EN stays 0 and O_BUSY=0.
- Exec request while 2 entries pending, M1 fetch arrives first -> fetch passes through unaltered; after drain, next M1 fetch gets C3.
- Assert I_RST_N=0 in LO state and while the FIFO holds entries -> O_OVR_EN and O_RAM_WE drop immediately; after release no further WE pulses and the FSM is IDLE.
